theta_lane_engine: RTL and testbench

- Parametrised, lane-serial successor to the bit-serial column-parity (theta) unit of the Keccak datapath.
- Accepts a 5x5 state of LANE_W-bit lanes over a valid/ready stream and accumulates the five column parities while loading.
- Computes the theta offsets D[x], then streams out the transformed state under back-pressure.
- Sits between the state-load unit and the rho/pi stage; a per-block bypass mode passes the state through unchanged.

---
 rtl/theta_lane_engine_if.sv | 32 +++
 rtl/theta_lane_engine.sv | 122 ++++++++++++
 tb/tb_theta_lane_engine.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/theta_lane_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : theta_lane_engine_if
//  Description : Lane stream and status bundle between the state-load unit,
//                the theta lane engine and the rho/pi stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface theta_lane_engine_if #(
    parameter int LANE_W = 64
);
    logic              mode;
    logic              in_valid;
    logic              in_ready;
    logic [LANE_W-1:0] in_lane;
    logic              out_valid;
    logic              out_ready;
    logic [LANE_W-1:0] out_lane;
    logic              out_last;
    logic              done;
    logic              busy;

    modport master (
        output mode, in_valid, in_lane, out_ready,
        input  in_ready, out_valid, out_lane, out_last, done, busy
    );

    modport slave (
        input  mode, in_valid, in_lane, out_ready,
        output in_ready, out_valid, out_lane, out_last, done, busy
    );
endinterface
`default_nettype wire

// File: rtl/theta_lane_engine.sv
`default_nettype none
// ============================================================================
//  Module      : theta_lane_engine
//  Description : Lane-serial Keccak theta step: loads 25 lanes while folding
//                column parities, then streams out A ^ D[x] (or A in bypass).
//  Revision    : 1.0 - initial release
// ============================================================================
module theta_lane_engine #(
    parameter int LANE_W    = 64,
    parameter int NUM_LANES = 25
) (
    input  logic               clk,
    input  logic               rst,
    theta_lane_engine_if.slave bus
);
    localparam logic [4:0] c_last_lane = 5'(NUM_LANES - 1);

    typedef enum logic [1:0] {
        c_load = 2'd0,
        c_calc = 2'd1,
        c_emit = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [4:0]        r_n;
    logic [2:0]        r_x;
    logic              r_mode;
    logic              r_done;
    logic [LANE_W-1:0] r_buf [NUM_LANES];
    logic [LANE_W-1:0] r_c   [5];
    logic [LANE_W-1:0] r_d   [5];
    logic [LANE_W-1:0] w_d   [5];
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_wrap;
    logic              w_emit;

    // rot1(v)[z] = v[z-1 mod LANE_W]; collapses to identity for LANE_W = 1
    function automatic logic [LANE_W-1:0] rot1(input logic [LANE_W-1:0] v);
        logic [LANE_W-1:0] r;
        for (int z = 0; z < LANE_W; z++) begin
            r[z] = v[(z + LANE_W - 1) % LANE_W];
        end
        return r;
    endfunction

    for (genvar gx = 0; gx < 5; gx++) begin : g_d
        assign w_d[gx] = r_mode ? '0 : (r_c[(gx + 4) % 5] ^ rot1(r_c[(gx + 1) % 5]));
    end

    assign w_wrap = (r_n == c_last_lane);
    assign w_emit = (r_state == c_emit);

    always_comb begin
        w_state_nxt = r_state;
        w_in_fire   = 1'b0;
        w_out_fire  = 1'b0;
        case (r_state)
            c_load: begin
                w_in_fire = bus.in_valid;
                if (w_in_fire && w_wrap) w_state_nxt = c_calc;
            end
            c_calc: w_state_nxt = c_emit;
            c_emit: begin
                w_out_fire = bus.out_ready;
                if (w_out_fire && w_wrap) w_state_nxt = c_load;
            end
            default: w_state_nxt = c_load;
        endcase
    end

    assign bus.in_ready  = (r_state == c_load);
    assign bus.out_valid = w_emit;
    assign bus.out_lane  = w_emit ? (r_buf[r_n] ^ r_d[r_x]) : '0;
    assign bus.out_last  = w_emit && w_wrap;
    assign bus.done      = r_done;
    assign bus.busy      = (r_state != c_load);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_load;
            r_n     <= '0;
            r_x     <= '0;
            r_mode  <= 1'b0;
            r_done  <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                r_c[i] <= '0;
                r_d[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_out_fire && w_wrap;
            // n and x = n mod 5 advance together on either stream
            if (w_in_fire || w_out_fire) begin
                r_n <= w_wrap ? '0 : r_n + 5'd1;
                r_x <= (w_wrap || r_x == 3'd4) ? '0 : r_x + 3'd1;
            end
            if (w_in_fire) begin
                if (r_n == '0) begin
                    r_mode <= bus.mode;
                    for (int i = 1; i < 5; i++) begin
                        r_c[i] <= '0;
                    end
                    r_c[0] <= bus.in_lane;
                end else begin
                    r_c[r_x] <= r_c[r_x] ^ bus.in_lane;
                end
            end
            if (r_state == c_calc) begin
                for (int i = 0; i < 5; i++) begin
                    r_d[i] <= w_d[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_fire) r_buf[r_n] <= bus.in_lane;
    end
endmodule
`default_nettype wire

// File: tb/tb_theta_lane_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_theta_lane_engine
//  Description : Scoreboard bench for theta_lane_engine at LANE_W 64 and 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_theta_lane_engine;
    typedef struct {
        logic [63:0] lane;
        bit          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    theta_lane_engine_if #(.LANE_W(64)) bus ();
    theta_lane_engine_if #(.LANE_W(1))  bus1 ();

    theta_lane_engine #(.LANE_W(64), .NUM_LANES(25)) dut (.clk(clk), .rst(rst), .bus(bus));
    theta_lane_engine #(.LANE_W(1),  .NUM_LANES(25)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    exp_t q64[$];
    exp_t q1[$];
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   ncyc      = 0;
    int   t_in_last = 0;
    int   rdy_mode  = 0;

    always @(posedge clk) ncyc <= ncyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, ncyc);
    endtask

    task automatic abort(input string name);
        n_checks++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, ncyc);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    endtask

    // Reference theta on a 5x5 state: parities, offsets, per-lane XOR
    task automatic push_ref(input logic [63:0] a [25], input bit md, input int w);
        logic [63:0] c [5];
        logic [63:0] d [5];
        logic [63:0] m;
        logic [63:0] r;
        exp_t        e;
        m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        for (int x = 0; x < 5; x++) c[x] = 64'd0;
        for (int n = 0; n < 25; n++) c[n % 5] ^= a[n] & m;
        for (int x = 0; x < 5; x++) begin
            r    = c[(x + 1) % 5];
            r    = ((r << 1) | (r >> (w - 1))) & m;
            d[x] = md ? 64'd0 : (c[(x + 4) % 5] ^ r);
        end
        for (int n = 0; n < 25; n++) begin
            e.lane = (a[n] ^ d[n % 5]) & m;
            e.last = (n == 24);
            if (w == 64) q64.push_back(e);
            else         q1.push_back(e);
        end
    endtask

    task automatic send64(input logic [63:0] a [25], input bit md, input int nl, input bit gaps);
        int guard;
        if (nl == 25) push_ref(a, md, 64);
        for (int n = 0; n < nl; n++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            bus.in_valid = 1'b1;
            bus.in_lane  = a[n];
            bus.mode     = (n == 0) ? md : 1'($urandom);
            guard = 0;
            do begin @(negedge clk); guard++; end while (!bus.in_ready && guard < 400);
            if (guard >= 400) abort("in_ready_wait");
            if (n == 24) t_in_last = ncyc;
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic send1(input logic [63:0] a [25], input bit md);
        int guard;
        push_ref(a, md, 1);
        for (int n = 0; n < 25; n++) begin
            bus1.in_valid = 1'b1;
            bus1.in_lane  = a[n][0];
            bus1.mode     = md;
            guard = 0;
            do begin @(negedge clk); guard++; end while (!bus1.in_ready && guard < 400);
            if (guard >= 400) abort("in_ready1_wait");
            @(posedge clk); #1;
            bus1.in_valid = 1'b0;
        end
    endtask

    task automatic check_reset();
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_last",  64'(bus.out_last),  64'd0);
        chk("rst_done",      64'(bus.done),      64'd0);
        chk("rst_busy",      64'(bus.busy),      64'd0);
        chk("rst_out_lane",  bus.out_lane,       64'd0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset();
        rst = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while ((q64.size() != 0 || q1.size() != 0) && guard < 600) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 600) abort("drain");
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: bus.out_ready = 1'b1;
            1: bus.out_ready = ~bus.out_ready;
            2: bus.out_ready = 1'($urandom);
            default: ;
        endcase
    end

    // Monitor for the 64-bit engine: stability, done pulse, latency, data
    bit          stall = 0;
    bit          exp_done = 0;
    bit          prev_valid = 0;
    logic [63:0] hold_lane;
    logic        hold_last;
    always @(negedge clk) begin
        exp_t e;
        bit   fire_last;
        if (rst) begin
            stall = 0; exp_done = 0; prev_valid = 0;
        end else begin
            fire_last = 0;
            chk("done", 64'(bus.done), 64'(exp_done));
            if (bus.busy) chk("in_ready_busy", 64'(bus.in_ready), 64'd0);
            if (stall && bus.out_valid) begin
                chk("stall_lane", bus.out_lane, hold_lane);
                chk("stall_last", 64'(bus.out_last), 64'(hold_last));
            end
            if (bus.out_valid && !prev_valid) chk("latency", 64'(ncyc - t_in_last), 64'd2);
            if (bus.out_valid && bus.out_ready) begin
                if (q64.size() == 0) chk("unexpected_out", 64'd1, 64'd0);
                else begin
                    e = q64.pop_front();
                    chk("out_lane", bus.out_lane, e.lane);
                    chk("out_last", 64'(bus.out_last), 64'(e.last));
                    fire_last = e.last;
                end
            end
            exp_done   = fire_last;
            stall      = bus.out_valid && !bus.out_ready;
            prev_valid = bus.out_valid;
            hold_lane  = bus.out_lane;
            hold_last  = bus.out_last;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus1.out_valid && bus1.out_ready) begin
            if (q1.size() == 0) chk("unexpected_out1", 64'd1, 64'd0);
            else begin
                e = q1.pop_front();
                chk("out_lane1", 64'(bus1.out_lane), e.lane);
                chk("out_last1", 64'(bus1.out_last), 64'(e.last));
            end
        end
    end

    initial begin
        logic [63:0] st [25];
        int          guard;
        bus.mode = 0; bus.in_valid = 0; bus.in_lane = '0; bus.out_ready = 0;
        bus1.mode = 0; bus1.in_valid = 0; bus1.in_lane = '0; bus1.out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        check_reset();
        rst = 1'b0;

        for (int n = 0; n < 25; n++) st[n] = 64'd0;
        send64(st, 1'b0, 25, 1'b0);
        drain();

        st[0] = 64'd1;
        send64(st, 1'b0, 25, 1'b0);
        drain();

        for (int n = 0; n < 25; n++) st[n] = 64'hFFFF_FFFF_FFFF_FFFF;
        send64(st, 1'b0, 25, 1'b0);
        drain();

        for (int n = 0; n < 25; n++) st[n] = {$urandom, $urandom};
        send64(st, 1'b1, 25, 1'b1);
        drain();

        for (int n = 0; n < 25; n++) st[n] = (n == 2) ? 64'd1 : 64'd0;
        send1(st, 1'b0);
        for (int n = 0; n < 25; n++) st[n] = 64'($urandom_range(0, 1));
        send1(st, 1'b0);
        drain();

        rdy_mode = 1;
        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 25; n++) st[n] = {$urandom, $urandom};
            send64(st, 1'b0, 25, 1'b1);
        end
        drain();
        rdy_mode = 2;
        for (int n = 0; n < 25; n++) st[n] = {$urandom, $urandom};
        send64(st, 1'b0, 25, 1'b1);
        drain();

        // Abort mid-load after 12 lanes, then mid-emit at n = 7
        rdy_mode = 0;
        for (int n = 0; n < 25; n++) st[n] = {$urandom, $urandom};
        send64(st, 1'b0, 12, 1'b0);
        pulse_reset();

        rdy_mode = 3;
        bus.out_ready = 1'b0;
        send64(st, 1'b0, 25, 1'b0);
        guard = 0;
        while (!bus.out_valid && guard < 20) begin @(posedge clk); #1; guard++; end
        if (guard >= 20) abort("emit_wait");
        bus.out_ready = 1'b1;
        repeat (7) begin @(posedge clk); #1; end
        bus.out_ready = 1'b0;
        pulse_reset();
        q64.delete();

        rdy_mode = 0;
        for (int n = 0; n < 25; n++) st[n] = {$urandom, $urandom};
        send64(st, 1'b0, 25, 1'b0);
        drain();
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
